// File: rtl/ni_axis_param_if.sv
// One valid/ready stream link; the master drives data/valid, the slave drives ready.
interface ni_axis_param_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ni_axis_param.sv
// GPU<->router network interface: TX maps GPU IDs to routing headers, RX filters on the
// own address and restores the GPU ID. Each direction is a FIFO plus an output register.

// One buffered direction: keep-qualified FIFO, output register and a saturating drop counter.
module ni_axis_param_chan #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_keep,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              push;
    logic              drop;
    logic              pop;

    // Ready comes only from registered occupancy, so it never depends on in_valid.
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && !full && in_keep;
    assign drop     = in_valid && !full && !in_keep;
    assign pop      = (count != '0) && (!out_valid || out_ready);
    assign level    = count + {{PTR_W{1'b0}}, out_valid};

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            // Output register refills from the head whenever it is free or being drained.
            if (pop) begin
                out_data  <= mem[rptr];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end
endmodule

module ni_axis_param #(
    parameter int unsigned GPU_ID      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ID_W        = 6,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned ADDR_OFFSET = 3,
    parameter int unsigned MAX_GPU     = 32,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    ni_axis_param_if.slave                gpu_in,
    ni_axis_param_if.master               router_out,
    ni_axis_param_if.slave                router_in,
    ni_axis_param_if.master               gpu_out,
    output logic [CNT_W-1:0]              tx_drop_cnt,
    output logic [CNT_W-1:0]              rx_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);
    localparam int unsigned    PAY_W    = DATA_W - ID_W;
    localparam logic [ID_W-1:0] OWN_ADDR = ID_W'(GPU_ID + ADDR_OFFSET);
    localparam logic [ID_W-1:0] OWN_ID   = ID_W'(GPU_ID);

    logic [ID_W-1:0]   tx_id;
    logic              tx_keep;
    logic [DATA_W-1:0] tx_data;
    logic              rx_keep;
    logic [DATA_W-1:0] rx_data;

    // Header rewrite happens before buffering, so the FIFOs hold router/GPU-ready flits.
    assign tx_id   = gpu_in.data[DATA_W-1 -: ID_W];
    assign tx_keep = (tx_id != '0) && (32'(tx_id) <= MAX_GPU);
    assign tx_data = {tx_id + ID_W'(ADDR_OFFSET), gpu_in.data[PAY_W-1:0]};
    assign rx_keep = (router_in.data[DATA_W-1 -: ID_W] == OWN_ADDR);
    assign rx_data = {OWN_ID, router_in.data[PAY_W-1:0]};

    ni_axis_param_chan #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .in_data   (tx_data),
        .in_valid  (gpu_in.valid),
        .in_keep   (tx_keep),
        .in_ready  (gpu_in.ready),
        .out_data  (router_out.data),
        .out_valid (router_out.valid),
        .out_ready (router_out.ready),
        .drop_cnt  (tx_drop_cnt),
        .level     (tx_level)
    );

    ni_axis_param_chan #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .in_data   (rx_data),
        .in_valid  (router_in.valid),
        .in_keep   (rx_keep),
        .in_ready  (router_in.ready),
        .out_data  (gpu_out.data),
        .out_valid (gpu_out.valid),
        .out_ready (gpu_out.ready),
        .drop_cnt  (rx_drop_cnt),
        .level     (rx_level)
    );
endmodule

// File: tb/tb_ni_axis_param.sv
// Self-checking bench for ni_axis_param: vector table, hand sequences and a randomized
// queue-based reference model on both directions.
module tb_ni_axis_param;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_drop_cnt, rx_drop_cnt;
    logic [3:0] tx_level, rx_level;
    logic [1:0] tx_drop_cnt2, rx_drop_cnt2;
    logic [3:0] tx_level2, rx_level2;
    int tests = 0;
    int fails = 0;

    ni_axis_param_if #(.DATA_W(16)) gi ();
    ni_axis_param_if #(.DATA_W(16)) ro ();
    ni_axis_param_if #(.DATA_W(16)) ri ();
    ni_axis_param_if #(.DATA_W(16)) go ();
    ni_axis_param_if #(.DATA_W(16)) gi2 ();
    ni_axis_param_if #(.DATA_W(16)) ro2 ();
    ni_axis_param_if #(.DATA_W(16)) ri2 ();
    ni_axis_param_if #(.DATA_W(16)) go2 ();

    ni_axis_param dut (
        .clk(clk), .reset(reset), .gpu_in(gi), .router_out(ro), .router_in(ri), .gpu_out(go),
        .tx_drop_cnt(tx_drop_cnt), .rx_drop_cnt(rx_drop_cnt), .tx_level(tx_level), .rx_level(rx_level)
    );

    ni_axis_param #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .gpu_in(gi2), .router_out(ro2), .router_in(ri2), .gpu_out(go2),
        .tx_drop_cnt(tx_drop_cnt2), .rx_drop_cnt(rx_drop_cnt2), .tx_level(tx_level2), .rx_level(rx_level2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rx;
        logic [15:0] din;
        bit          exp_v;
        logic [15:0] exp_d;
        int          exp_drop;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gi.valid = 0; gi.data = '0; ri.valid = 0; ri.data = '0;
        ro.ready = 1; go.ready = 1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    // Reference mapping rules, written as plain arithmetic on the ID field.
    function automatic void tx_model(input logic [15:0] d, output bit legal, output logic [15:0] m);
        int id;
        id = int'(d) / 1024;
        legal = (id >= 1) && (id <= 32);
        m = 16'(((id + 3) % 64) * 1024 + int'(d) % 1024);
    endfunction

    function automatic void rx_model(input logic [15:0] d, output bit legal, output logic [15:0] m);
        legal = (int'(d) / 1024) == 23;
        m = 16'(20 * 1024 + int'(d) % 1024);
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        logic [15:0] txq[$];
        logic [15:0] rxq[$];
        logic [15:0] m, exp_d;
        bit legal;
        int accepted, k, txd, rxd;

        vecs[0] = '{0, 16'h5023, 1, 16'h5C23, 0};
        vecs[1] = '{0, 16'h07FF, 1, 16'h13FF, 0};
        vecs[2] = '{0, 16'h8155, 1, 16'h8D55, 0};
        vecs[3] = '{0, 16'h0001, 0, 16'h0000, 1};
        vecs[4] = '{0, 16'h8402, 0, 16'h0000, 2};
        vecs[5] = '{0, 16'hFC00, 0, 16'h0000, 3};
        vecs[6] = '{1, 16'h5C7F, 1, 16'h507F, 0};
        vecs[7] = '{1, 16'h6000, 0, 16'h0000, 1};
        vecs[8] = '{1, 16'h5FFF, 1, 16'h53FF, 1};
        vecs[9] = '{1, 16'h0000, 0, 16'h0000, 2};

        gi2.valid = 0; gi2.data = '0; ri2.valid = 0; ri2.data = '0; ro2.ready = 1; go2.ready = 1;
        do_reset();

        // Reset state
        check("rst_router_valid", ro.valid, 0);
        check("rst_gpu_valid", go.valid, 0);
        check("rst_router_data", ro.data, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_tx_drop", tx_drop_cnt, 0);

        // Single-beat table: mapping, filtering and drop counting
        foreach (vecs[i]) begin
            if (vecs[i].is_rx) begin ri.data = vecs[i].din; ri.valid = 1; end
            else begin gi.data = vecs[i].din; gi.valid = 1; end
            step();
            ri.valid = 0; gi.valid = 0;
            step();
            if (vecs[i].is_rx) begin
                check($sformatf("vec%0d_rx_valid", i), go.valid, vecs[i].exp_v);
                if (vecs[i].exp_v) check($sformatf("vec%0d_rx_data", i), go.data, vecs[i].exp_d);
                check($sformatf("vec%0d_rx_drop", i), rx_drop_cnt, vecs[i].exp_drop);
            end else begin
                check($sformatf("vec%0d_tx_valid", i), ro.valid, vecs[i].exp_v);
                if (vecs[i].exp_v) check($sformatf("vec%0d_tx_data", i), ro.data, vecs[i].exp_d);
                check($sformatf("vec%0d_tx_drop", i), tx_drop_cnt, vecs[i].exp_drop);
            end
            step();
            check($sformatf("vec%0d_one_cycle", i), vecs[i].is_rx ? go.valid : ro.valid, 0);
        end

        // Drop counter saturation on the CNT_W=2 instance
        gi2.data = 16'h0000; gi2.valid = 1;
        for (int i = 0; i < 3; i++) step();
        check("sat_cnt_at3", tx_drop_cnt2, 3);
        for (int i = 0; i < 2; i++) step();
        gi2.valid = 0;
        step();
        check("sat_cnt_held", tx_drop_cnt2, 3);
        check("sat_no_router_beat", ro2.valid, 0);

        // Backpressure: 9 beats fill FIFO plus output register
        do_reset();
        ro.ready = 0;
        accepted = 0;
        for (int i = 0; i < 30 && accepted < 9; i++) begin
            gi.data = 16'h5000 | 16'(accepted); gi.valid = 1;
            if (gi.ready) accepted++;
            step();
        end
        gi.valid = 0;
        check("bp_accepted", accepted, 9);
        check("bp_ready_low", gi.ready, 0);
        check("bp_tx_level", tx_level, 9);
        check("bp_head_valid", ro.valid, 1);
        check("bp_head_data", ro.data, 16'h5C00);
        gi.data = 16'h5123; gi.valid = 1;
        for (int i = 0; i < 3; i++) step();
        gi.valid = 0;
        check("bp_held_valid", ro.valid, 1);
        check("bp_held_data", ro.data, 16'h5C00);
        check("bp_held_level", tx_level, 9);
        ro.ready = 1;
        k = 0;
        for (int i = 0; i < 40 && k < 9; i++) begin
            if (ro.valid) begin
                check($sformatf("bp_out%0d", k), ro.data, 16'h5C00 | 16'(k));
                k++;
            end
            step();
        end
        check("bp_out_count", k, 9);
        check("bp_drained", ro.valid, 0);

        // Randomized traffic on both directions against queue model
        do_reset();
        txd = 0; rxd = 0;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_tx_level", tx_level, txq.size());
            check("rnd_rx_level", rx_level, rxq.size());
            check("rnd_tx_ready", gi.ready, txq.size() < 9);
            check("rnd_rx_ready", ri.ready, rxq.size() < 9);
            gi.valid = ($urandom_range(0, 1) == 1);
            gi.data = {6'($urandom_range(0, 40)), 10'($urandom)};
            ro.ready = ($urandom_range(0, 2) != 0);
            ri.valid = ($urandom_range(0, 1) == 1);
            ri.data = ($urandom_range(0, 3) != 0) ? {6'd23, 10'($urandom)} : 16'($urandom);
            go.ready = ($urandom_range(0, 2) != 0);
            if (gi.valid && gi.ready) begin
                tx_model(gi.data, legal, m);
                if (legal) txq.push_back(m); else if (txd < 255) txd++;
            end
            if (ri.valid && ri.ready) begin
                rx_model(ri.data, legal, m);
                if (legal) rxq.push_back(m); else if (rxd < 255) rxd++;
            end
            if (ro.valid && ro.ready) begin
                if (txq.size() == 0) check("rnd_tx_spurious", ro.valid, 0);
                else begin exp_d = txq.pop_front(); check("rnd_tx_data", ro.data, exp_d); end
            end
            if (go.valid && go.ready) begin
                if (rxq.size() == 0) check("rnd_rx_spurious", go.valid, 0);
                else begin exp_d = rxq.pop_front(); check("rnd_rx_data", go.data, exp_d); end
            end
            step();
        end
        check("rnd_tx_drop", tx_drop_cnt, txd);
        check("rnd_rx_drop", rx_drop_cnt, rxd);
        gi.valid = 0; ri.valid = 0;

        // Reset with both directions partly full discards everything
        do_reset();
        ro.ready = 0; go.ready = 0;
        for (int i = 0; i < 4; i++) begin
            gi.data = 16'h5000 | 16'(i); gi.valid = 1;
            ri.data = 16'h5C00 | 16'(i); ri.valid = 1;
            step();
        end
        gi.valid = 0; ri.valid = 0;
        step();
        check("t6_pre_tx_level", tx_level, 4);
        check("t6_pre_rx_level", rx_level, 4);
        #2 reset = 1'b1;
        #1;
        check("t6_tx_valid_async", ro.valid, 0);
        check("t6_rx_valid_async", go.valid, 0);
        check("t6_tx_level_async", tx_level, 0);
        check("t6_rx_level_async", rx_level, 0);
        step();
        reset = 1'b0;
        step();
        ro.ready = 1; go.ready = 1;
        gi.data = 16'h5055; gi.valid = 1;
        ri.data = 16'h5C11; ri.valid = 1;
        step();
        gi.valid = 0; ri.valid = 0;
        for (int i = 0; i < 10 && !ro.valid; i++) step();
        check("t6_tx_first_valid", ro.valid, 1);
        check("t6_tx_first_data", ro.data, 16'h5C55);
        check("t6_rx_first_valid", go.valid, 1);
        check("t6_rx_first_data", go.data, 16'h5011);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
